// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter: IDLE/SERVE handshake, one access per two cycles.
// Optional macro DMEM_ARB_RR_EN: round-robin tie-break (default: requester A wins ties).
module dmem_arbiter (
   input  logic        CLK,
   input  logic        Reset,
   input  logic        a_req,
   input  logic        a_we,
   input  logic [31:0] a_addr,
   input  logic [31:0] a_wdata,
   output logic        a_ack,
   output logic        a_err,
   output logic [31:0] a_rdata,
   input  logic        b_req,
   input  logic        b_we,
   input  logic [31:0] b_addr,
   input  logic [31:0] b_wdata,
   output logic        b_ack,
   output logic        b_err,
   output logic [31:0] b_rdata,
   output logic        mem_MemRead,
   output logic        mem_MemWrite,
   output logic [31:0] mem_DataAddr,
   output logic [31:0] mem_writeData,
   input  logic [31:0] mem_readData,
   output logic        busy
);

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned NWORDS = 32;

   typedef enum logic {IDLE, SERVE} state_t;

   state_t              state;
   logic                last_grant;   // 0 = A, 1 = B; doubles as the grant of the access in SERVE
   logic                lat_we;
   logic                pick_b;
   logic                sel_we;
   logic                sel_oor;
   logic [ADDR_W-1:0]   sel_addr;
   logic [31:0]         sel_wdata;

   // Winner selection and mux of the winner's request fields
   always_comb begin
      pick_b = 1'b0;
`ifdef DMEM_ARB_RR_EN
      pick_b = b_req & (~a_req | ~last_grant);
`else
      pick_b = b_req & ~a_req;
`endif
      sel_we    = pick_b ? b_we    : a_we;
      sel_addr  = pick_b ? b_addr  : a_addr;
      sel_wdata = pick_b ? b_wdata : a_wdata;
      sel_oor   = (sel_addr >= ADDR_W'(NWORDS));
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         state         <= IDLE;
         last_grant    <= 1'b0;
         lat_we        <= 1'b0;
         busy          <= 1'b0;
         a_ack         <= 1'b0;
         b_ack         <= 1'b0;
         a_err         <= 1'b0;
         b_err         <= 1'b0;
         mem_MemRead   <= 1'b0;
         mem_MemWrite  <= 1'b0;
         mem_DataAddr  <= '0;
         mem_writeData <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (a_req | b_req) begin
                  state         <= SERVE;
                  last_grant    <= pick_b;
                  lat_we        <= sel_we;
                  busy          <= 1'b1;
                  a_ack         <= ~pick_b;
                  b_ack         <= pick_b;
                  a_err         <= ~pick_b & sel_oor;
                  b_err         <= pick_b & sel_oor;
                  mem_MemWrite  <= sel_we & ~sel_oor;
                  mem_MemRead   <= ~sel_we & ~sel_oor;
                  mem_DataAddr  <= sel_addr;
                  mem_writeData <= sel_wdata;
               end
            end
            SERVE: begin
               state         <= IDLE;
               busy          <= 1'b0;
               a_ack         <= 1'b0;
               b_ack         <= 1'b0;
               a_err         <= 1'b0;
               b_err         <= 1'b0;
               mem_MemRead   <= 1'b0;
               mem_MemWrite  <= 1'b0;
               mem_DataAddr  <= '0;
               mem_writeData <= '0;
            end
         endcase
      end
   end

   // Read data passes through only for a successful read to the granted side
   assign a_rdata = (a_ack & ~last_grant & ~lat_we & ~a_err) ? mem_readData : '0;
   assign b_rdata = (b_ack &  last_grant & ~lat_we & ~b_err) ? mem_readData : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized accesses
// compared against a transaction-level model of the memory and arbitration policy.
module tb_dmem_arbiter;

   logic        CLK;
   logic        Reset;
   logic        a_req, a_we, a_ack, a_err;
   logic [31:0] a_addr, a_wdata, a_rdata;
   logic        b_req, b_we, b_ack, b_err;
   logic [31:0] b_addr, b_wdata, b_rdata;
   logic        mem_MemRead, mem_MemWrite, busy;
   logic [31:0] mem_DataAddr, mem_writeData, mem_readData;

   int checks = 0;
   int errors = 0;

   dmem_arbiter dut (
      .CLK(CLK), .Reset(Reset),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_ack(a_ack), .a_err(a_err), .a_rdata(a_rdata),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_ack(b_ack), .b_err(b_err), .b_rdata(b_rdata),
      .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite),
      .mem_DataAddr(mem_DataAddr), .mem_writeData(mem_writeData),
      .mem_readData(mem_readData), .busy(busy)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Data memory: combinational read, write commits on negedge
   logic [31:0] mem [0:31];
   logic        mem_clear;
   always @(negedge CLK) begin
      if (mem_clear) begin
         for (int i = 0; i < 32; i++) mem[i] <= (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000;
      end else if (mem_MemWrite) begin
         mem[mem_DataAddr[4:0]] <= mem_writeData;
      end
   end
   assign mem_readData = mem[mem_DataAddr[4:0]];

   // Reference model state
   logic [31:0] ref_mem [0:31];
   logic        model_last;   // 1 = B granted last

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_aack"}, 32'(a_ack), 32'd0);
      chk({tag, "_back"}, 32'(b_ack), 32'd0);
      chk({tag, "_strobes"}, 32'({mem_MemRead, mem_MemWrite}), 32'd0);
      chk({tag, "_addr"}, mem_DataAddr, 32'd0);
   endtask

   // One complete access starting from IDLE; model picks the winner from the policy
   task automatic access(input string tag,
                         input logic ae, input logic awe, input logic [31:0] aad, input logic [31:0] awd,
                         input logic be, input logic bwe, input logic [31:0] bad, input logic [31:0] bwd);
      logic        win_b, we, oor;
      logic [31:0] addr, wd, exp_rd;
      logic [4:0]  idx;
      a_req = ae; a_we = awe; a_addr = aad; a_wdata = awd;
      b_req = be; b_we = bwe; b_addr = bad; b_wdata = bwd;
      if (ae && be) begin
`ifdef DMEM_ARB_RR_EN
         win_b = ~model_last;
`else
         win_b = 1'b0;
`endif
      end else begin
         win_b = be;
      end
      we   = win_b ? bwe : awe;
      addr = win_b ? bad : aad;
      wd   = win_b ? bwd : awd;
      oor  = (addr > 32'd31);
      idx  = addr[4:0];
      exp_rd = (!we && !oor) ? ref_mem[idx] : 32'd0;
      step();
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      chk({tag, "_aack"}, 32'(a_ack), 32'(!win_b));
      chk({tag, "_back"}, 32'(b_ack), 32'(win_b));
      chk({tag, "_aerr"}, 32'(a_err), 32'(!win_b && oor));
      chk({tag, "_berr"}, 32'(b_err), 32'(win_b && oor));
      chk({tag, "_memwr"}, 32'(mem_MemWrite), 32'(we && !oor));
      chk({tag, "_memrd"}, 32'(mem_MemRead), 32'(!we && !oor));
      chk({tag, "_maddr"}, mem_DataAddr, addr);
      chk({tag, "_mwdata"}, mem_writeData, wd);
      chk({tag, "_ardata"}, a_rdata, win_b ? 32'd0 : exp_rd);
      chk({tag, "_brdata"}, b_rdata, win_b ? exp_rd : 32'd0);
      a_req = 1'b0; b_req = 1'b0;
      step();
      chk_idle({tag, "_gap"});
      if (we && !oor) ref_mem[idx] = wd;
      model_last = win_b;
   endtask

   logic        exp_tie_b [0:3];
   logic [31:0] saved;

   initial begin
      a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
      b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
      Reset = 1'b1; mem_clear = 1'b1;
      for (int i = 0; i < 32; i++) ref_mem[i] = (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000;
      model_last = 1'b0;
      step(); step();
      mem_clear = 1'b0;
      chk_idle("reset");
      chk("reset_aerr", 32'(a_err), 32'd0);
      chk("reset_ardata", a_rdata, 32'd0);
      Reset = 1'b0;
      step();
      chk_idle("post_reset");

      // Single write then read-back
      access("wr5", 1, 1, 32'd5, 32'hDEAD_BEEF, 0, 0, 0, 0);
      access("rd5", 1, 0, 32'd5, 32'h0, 0, 0, 0, 0);
      chk("rd5_model", ref_mem[5], 32'hDEAD_BEEF);

      // Out-of-range read on B, and boundary addresses
      access("oor32", 0, 0, 0, 0, 1, 0, 32'd32, 32'h0);
      access("b_rd31", 0, 0, 0, 0, 1, 0, 32'd31, 32'h0);
      access("a_wroor", 1, 1, 32'hFFFF_FFFF, 32'h1234_5678, 0, 0, 0, 0);

      // Input change after grant: latched address must hold
      a_req = 1; a_we = 0; a_addr = 32'd3;
      step();
      chk("chg_maddr0", mem_DataAddr, 32'd3);
      a_addr = 32'd7; a_req = 0;
      #2;
      chk("chg_maddr1", mem_DataAddr, 32'd3);
      chk("chg_rdata", a_rdata, ref_mem[3]);
      step();
      chk_idle("chg_gap");
      model_last = 1'b0;

      // Reset during SERVE aborts; committed write stands
      a_req = 1; a_we = 1; a_addr = 32'd9; a_wdata = 32'hCAFE_F00D;
      step();
      chk("rst_busy0", 32'(busy), 32'd1);
      chk("rst_memwr", 32'(mem_MemWrite), 32'd1);
      Reset = 1'b1; a_req = 0;
      step();
      chk_idle("rst_abort");
      ref_mem[9] = 32'hCAFE_F00D;
      model_last = 1'b0;
      Reset = 1'b0;
      access("rst_after", 1, 0, 32'd9, 32'h0, 0, 0, 0, 0);

      // Tie with both requests held from reset
`ifdef DMEM_ARB_RR_EN
      exp_tie_b[0] = 1; exp_tie_b[1] = 0; exp_tie_b[2] = 1; exp_tie_b[3] = 0;
`else
      exp_tie_b[0] = 0; exp_tie_b[1] = 0; exp_tie_b[2] = 0; exp_tie_b[3] = 0;
`endif
      Reset = 1'b1;
      a_req = 1; a_we = 0; a_addr = 32'd1;
      b_req = 1; b_we = 0; b_addr = 32'd2;
      step();
      Reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
         step();
         chk("tie_busy", 32'(busy), 32'd1);
         chk("tie_aack", 32'(a_ack), 32'(!exp_tie_b[k]));
         chk("tie_back", 32'(b_ack), 32'(exp_tie_b[k]));
         saved = exp_tie_b[k] ? ref_mem[2] : ref_mem[1];
         chk("tie_rdata", exp_tie_b[k] ? b_rdata : a_rdata, saved);
         step();
         chk("tie_gap_busy", 32'(busy), 32'd0);
         chk("tie_gap_ack", 32'({a_ack, b_ack}), 32'd0);
      end
      a_req = 0; b_req = 0;
      model_last = exp_tie_b[3];
      step();
      chk_idle("tie_end");

      // Randomized accesses, including contention and out-of-range addresses
      for (int n = 0; n < 40; n++) begin
         logic ae, be;
         ae = 1'($urandom_range(0, 1));
         be = 1'($urandom_range(0, 1));
         if (!ae && !be) ae = 1'b1;
         access("rnd", ae, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 39)), $urandom,
                be, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 39)), $urandom);
         if ($urandom_range(0, 3) == 0) begin
            step();
            chk_idle("rnd_idle");
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
